// File: rtl/frp_rx_decoder_if.sv
// Symbol-in / word-out bundle of the FRP receive decoder: line-side symbol strobe,
// core-side valid/ready word handshake, status flags and statistics.
interface frp_rx_decoder_if #(
  parameter int CNT_W = 16
);
  logic             Rx_Sym_Valid;
  logic             Rx_Sof;
  logic             Rx_Flip;
  logic             Rx_Rotation;
  logic             Rx_Polarity;
  logic [15:0]      Rx_Data;
  logic             Rx_Data_Valid;
  logic             Rx_Data_Ready;
  logic             Rx_Err;
  logic             Rx_Overrun;
  logic             Rx_Resync;
  logic [CNT_W-1:0] Frame_Cnt;
  logic [CNT_W-1:0] Err_Cnt;
  logic             Clr_Stats;

  modport master (
    output Rx_Sym_Valid, Rx_Sof, Rx_Flip, Rx_Rotation, Rx_Polarity,
    output Rx_Data_Ready, Clr_Stats,
    input  Rx_Data, Rx_Data_Valid, Rx_Err, Rx_Overrun, Rx_Resync,
    input  Frame_Cnt, Err_Cnt
  );

  modport slave (
    input  Rx_Sym_Valid, Rx_Sof, Rx_Flip, Rx_Rotation, Rx_Polarity,
    input  Rx_Data_Ready, Clr_Stats,
    output Rx_Data, Rx_Data_Valid, Rx_Err, Rx_Overrun, Rx_Resync,
    output Frame_Cnt, Err_Cnt
  );
endinterface

// File: rtl/frp_rx_decoder.sv
// FRP receive decoder: assembles 7-symbol Flip/Rotation/Polarity frames, checks the
// redundancy bits and hands the 16-bit word to the core through a 1-deep buffer.
module frp_rx_decoder #(
  parameter int ERR_DROP = 0,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  frp_rx_decoder_if.slave bus
);

  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  function automatic logic [15:0] frame_data(input logic [6:0] f,
                                             input logic [6:0] r,
                                             input logic [6:0] p);
    logic [15:0] d;
    d = '0;
    for (int k = 0; k < 7; k++) begin
      d[2*k+1] = r[k];
      d[2*k]   = p[k];
    end
    d[15:14] = {f[6], f[5]};
    return d;
  endfunction

  function automatic logic frame_err(input logic [6:0] f, input logic [15:0] d);
    return (f[4] != ^d) || (f[3:0] != (d[13:10] ^ d[3:0]));
  endfunction

  logic [0:0]       state_p0;
  logic [2:0]       idx_p0;
  logic [6:0]       f_p0;
  logic [6:0]       r_p0;
  logic [6:0]       p_p0;

  logic [15:0]      data_p1;
  logic             vld_p1;
  logic             err_p1;
  logic             ovr_p1;
  logic             resync_p1;
  logic [CNT_W-1:0] frame_cnt_p1;
  logic [CNT_W-1:0] err_cnt_p1;

  logic             sym_acc;
  logic             resync_hit;
  logic             done;
  logic [2:0]       wr_idx;
  logic [6:0]       f_cur;
  logic [6:0]       r_cur;
  logic [6:0]       p_cur;
  logic [15:0]      word_c;
  logic             err_c;
  logic             take;
  logic             room;
  logic             keep;
  logic             load;
  logic             ovr_set;

  always_comb begin
    sym_acc    = bus.Rx_Sym_Valid && ((state_p0 == COLLECT) || bus.Rx_Sof);
    resync_hit = bus.Rx_Sym_Valid && bus.Rx_Sof && (state_p0 == COLLECT);
    done       = bus.Rx_Sym_Valid && !bus.Rx_Sof && (state_p0 == COLLECT) &&
                 (idx_p0 == 3'd6);
    wr_idx     = bus.Rx_Sof ? 3'd0 : idx_p0;
    // The completing symbol is spliced in combinationally so the word loads on its edge.
    f_cur      = {bus.Rx_Flip,     f_p0[5:0]};
    r_cur      = {bus.Rx_Rotation, r_p0[5:0]};
    p_cur      = {bus.Rx_Polarity, p_p0[5:0]};
    word_c     = frame_data(f_cur, r_cur, p_cur);
    err_c      = frame_err(f_cur, word_c);
    take       = vld_p1 && bus.Rx_Data_Ready;
    room       = !vld_p1 || bus.Rx_Data_Ready;
    keep       = (ERR_DROP == 0) || !err_c;
    load       = done && room && keep;
    ovr_set    = done && !room;
  end

  // Stage p0: frame assembly (symbol store carries no reset; it is only read once full)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= HUNT;
      idx_p0   <= 3'd0;
    end else if (sym_acc) begin
      if (bus.Rx_Sof) begin
        state_p0 <= COLLECT;
        idx_p0   <= 3'd1;
      end else if (idx_p0 == 3'd6) begin
        state_p0 <= HUNT;
        idx_p0   <= 3'd0;
      end else begin
        idx_p0 <= idx_p0 + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sym_acc) begin
      f_p0[wr_idx] <= bus.Rx_Flip;
      r_p0[wr_idx] <= bus.Rx_Rotation;
      p_p0[wr_idx] <= bus.Rx_Polarity;
    end
  end

  // Stage p1: output buffer, status flags and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1      <= 16'd0;
      vld_p1       <= 1'b0;
      err_p1       <= 1'b0;
      ovr_p1       <= 1'b0;
      resync_p1    <= 1'b0;
      frame_cnt_p1 <= '0;
      err_cnt_p1   <= '0;
    end else begin
      if (load) begin
        data_p1 <= word_c;
        err_p1  <= err_c;
      end
      vld_p1    <= load || (vld_p1 && !take);
      resync_p1 <= resync_hit;
      ovr_p1    <= bus.Clr_Stats ? 1'b0 : (ovr_p1 || ovr_set);
      if (bus.Clr_Stats) begin
        frame_cnt_p1 <= '0;
        err_cnt_p1   <= '0;
      end else begin
        if (done)          frame_cnt_p1 <= frame_cnt_p1 + CNT_W'(1);
        if (done && err_c) err_cnt_p1   <= err_cnt_p1 + CNT_W'(1);
      end
    end
  end

  assign bus.Rx_Data       = data_p1;
  assign bus.Rx_Data_Valid = vld_p1;
  assign bus.Rx_Err        = err_p1;
  assign bus.Rx_Overrun    = ovr_p1;
  assign bus.Rx_Resync     = resync_p1;
  assign bus.Frame_Cnt     = frame_cnt_p1;
  assign bus.Err_Cnt       = err_cnt_p1;

endmodule

// File: tb/tb_frp_rx_decoder.sv
// Bench for frp_rx_decoder: two instances (deliver-on-error with 16-bit counters,
// drop-on-error with 4-bit wrapping counters) fed the same symbol stream.
module tb_frp_rx_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sv = 1'b0, sof = 1'b0, fl = 1'b0, ro = 1'b0, po = 1'b0, rdy = 1'b0, clr = 1'b0;

  frp_rx_decoder_if #(.CNT_W(16)) bus0 ();
  frp_rx_decoder_if #(.CNT_W(4))  bus1 ();

  assign bus0.Rx_Sym_Valid  = sv;
  assign bus0.Rx_Sof        = sof;
  assign bus0.Rx_Flip       = fl;
  assign bus0.Rx_Rotation   = ro;
  assign bus0.Rx_Polarity   = po;
  assign bus0.Rx_Data_Ready = rdy;
  assign bus0.Clr_Stats     = clr;
  assign bus1.Rx_Sym_Valid  = sv;
  assign bus1.Rx_Sof        = sof;
  assign bus1.Rx_Flip       = fl;
  assign bus1.Rx_Rotation   = ro;
  assign bus1.Rx_Polarity   = po;
  assign bus1.Rx_Data_Ready = rdy;
  assign bus1.Clr_Stats     = clr;

  frp_rx_decoder #(.ERR_DROP(0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  frp_rx_decoder #(.ERR_DROP(1), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic [15:0] o_data [2];
  logic        o_vld  [2];
  logic        o_err  [2];
  logic        o_ovr  [2];
  logic        o_rsy  [2];
  logic [15:0] o_fcnt [2];
  logic [15:0] o_ecnt [2];
  assign o_data[0] = bus0.Rx_Data;
  assign o_vld[0]  = bus0.Rx_Data_Valid;
  assign o_err[0]  = bus0.Rx_Err;
  assign o_ovr[0]  = bus0.Rx_Overrun;
  assign o_rsy[0]  = bus0.Rx_Resync;
  assign o_fcnt[0] = bus0.Frame_Cnt;
  assign o_ecnt[0] = bus0.Err_Cnt;
  assign o_data[1] = bus1.Rx_Data;
  assign o_vld[1]  = bus1.Rx_Data_Valid;
  assign o_err[1]  = bus1.Rx_Err;
  assign o_ovr[1]  = bus1.Rx_Overrun;
  assign o_rsy[1]  = bus1.Rx_Resync;
  assign o_fcnt[1] = {12'd0, bus1.Frame_Cnt};
  assign o_ecnt[1] = {12'd0, bus1.Err_Cnt};

  // Reference model: symbols collected so far (m_n == 0 means hunting for Sof).
  logic [2:0]  m_sym [7];
  int          m_n;
  logic [15:0] m_data [2];
  logic        m_vld  [2];
  logic        m_err  [2];
  logic        m_ovr  [2];
  logic        m_rsy;
  int unsigned m_fcnt, m_ecnt;

  logic rand_rdy = 1'b0;
  int   clr_pct  = 0;
  int   errors   = 0;
  int   checks   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [2:0] s [7]);
    int w;
    w = 0;
    for (int k = 0; k < 7; k++) w += int'(s[k][1:0]) * (1 << (2 * k));
    w += int'(s[6][2]) * 32768 + int'(s[5][2]) * 16384;
    return 16'(w);
  endfunction

  function automatic logic model_bad(input logic [2:0] s [7], input logic [15:0] w);
    int wi, par, want, got4;
    wi   = int'(w);
    par  = $countones(w) % 2;
    want = ((wi / 1024) % 16) ^ (wi % 16);
    got4 = int'(s[3][2]) * 8 + int'(s[2][2]) * 4 + int'(s[1][2]) * 2 + int'(s[0][2]);
    return (int'(s[4][2]) != par) || (got4 != want);
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_rsy = 1'b0;
    m_fcnt = 0;
    m_ecnt = 0;
    for (int d = 0; d < 2; d++) begin
      m_data[d] = 16'd0;
      m_vld[d]  = 1'b0;
      m_err[d]  = 1'b0;
      m_ovr[d]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic done, bad;
    logic [15:0] w;
    done = 1'b0;
    bad = 1'b0;
    w = 16'd0;
    m_rsy = 1'b0;
    if (sv) begin
      if (sof) begin
        if (m_n > 0) m_rsy = 1'b1;
        m_sym[0] = {fl, ro, po};
        m_n = 1;
      end else if (m_n > 0) begin
        m_sym[m_n] = {fl, ro, po};
        m_n++;
        if (m_n == 7) begin
          done = 1'b1;
          m_n = 0;
          w = model_word(m_sym);
          bad = model_bad(m_sym, w);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (done && m_vld[d] && !rdy) m_ovr[d] = 1'b1;
      else if (done && !(d == 1 && bad)) begin
        m_data[d] = w;
        m_err[d]  = bad;
        m_vld[d]  = 1'b1;
      end else if (m_vld[d] && rdy) m_vld[d] = 1'b0;
      if (clr) m_ovr[d] = 1'b0;
    end
    if (clr) begin
      m_fcnt = 0;
      m_ecnt = 0;
    end else begin
      m_fcnt += 32'(done);
      m_ecnt += 32'(done && bad);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] msk;
      msk = (d == 0) ? 32'hFFFF : 32'hF;
      chk($sformatf("valid%0d", d),     32'(o_vld[d]),  32'(m_vld[d]));
      chk($sformatf("data%0d", d),      32'(o_data[d]), 32'(m_data[d]));
      chk($sformatf("err%0d", d),       32'(o_err[d]),  32'(m_err[d]));
      chk($sformatf("overrun%0d", d),   32'(o_ovr[d]),  32'(m_ovr[d]));
      chk($sformatf("resync%0d", d),    32'(o_rsy[d]),  32'(m_rsy));
      chk($sformatf("frame_cnt%0d", d), 32'(o_fcnt[d]), m_fcnt & msk);
      chk($sformatf("err_cnt%0d", d),   32'(o_ecnt[d]), m_ecnt & msk);
    end
  endtask

  task automatic tick();
    if (rand_rdy) rdy = 1'($urandom_range(0, 1));
    if (clr_pct > 0) clr = ($urandom_range(0, 99) < clr_pct);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    sv = 1'b0;
    sof = 1'b0;
    repeat (n) tick();
  endtask

  task automatic put_sym(input logic s, input logic [2:0] b);
    sv = 1'b1;
    sof = s;
    {fl, ro, po} = b;
    tick();
    sv = 1'b0;
    sof = 1'b0;
  endtask

  task automatic clear();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  function automatic logic [6:0] enc_flip(input logic [15:0] w, input logic bad);
    return {w[15], w[14], (^w) ^ bad, w[13:10] ^ w[3:0]};
  endfunction

  task automatic send_frame(input logic [15:0] w, input logic bad, input int gap_pct,
                            input int nsym);
    logic [6:0] f;
    f = enc_flip(w, bad);
    for (int k = 0; k < nsym; k++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 2));
      put_sym(k == 0, {f[k], w[2*k+1], w[2*k]});
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",     32'(o_vld[0]),  0);
    chk("rst_data",      32'(o_data[0]), 0);
    chk("rst_err",       32'(o_err[0]),  0);
    chk("rst_overrun",   32'(o_ovr[0]),  0);
    chk("rst_resync",    32'(o_rsy[0]),  0);
    chk("rst_frame_cnt", 32'(o_fcnt[0]), 0);
    chk("rst_err_cnt",   32'(o_ecnt[0]), 0);
    rst_n = 1'b1;
    rdy = 1'b1;
    idle(2);

    // Good frame, back-to-back symbols
    clear();
    send_frame(16'hA5C3, 1'b0, 0, 7);
    chk("good_data",      32'(o_data[0]), 32'hA5C3);
    chk("good_valid",     32'(o_vld[0]),  1);
    chk("good_err",       32'(o_err[0]),  0);
    chk("good_frame_cnt", 32'(o_fcnt[0]), 1);
    idle(1);
    chk("good_valid_one_cycle", 32'(o_vld[0]), 0);

    // f_4 inverted
    clear();
    send_frame(16'hA5C3, 1'b1, 0, 7);
    chk("bad_data",       32'(o_data[0]), 32'hA5C3);
    chk("bad_err",        32'(o_err[0]),  1);
    chk("bad_err_cnt",    32'(o_ecnt[0]), 1);
    chk("drop_valid",     32'(o_vld[1]),  0);
    chk("drop_err_cnt",   32'(o_ecnt[1]), 1);
    chk("drop_frame_cnt", 32'(o_fcnt[1]), 1);
    idle(2);

    // Overrun with Ready low
    clear();
    rdy = 1'b0;
    send_frame(16'hA5C3, 1'b0, 0, 7);
    send_frame(16'h0000, 1'b0, 0, 7);
    chk("ovr_data_held", 32'(o_data[0]), 32'hA5C3);
    chk("ovr_flag",      32'(o_ovr[0]),  1);
    rdy = 1'b1;
    idle(1);
    chk("ovr_valid_after_accept", 32'(o_vld[0]),  0);
    chk("ovr_frame_cnt",          32'(o_fcnt[0]), 2);

    // Sof at k=3 restarts the frame
    clear();
    send_frame(16'hA5C3, 1'b0, 0, 3);
    put_sym(1'b1, 3'b000);
    chk("resync_pulse", 32'(o_rsy[0]), 1);
    for (int k = 1; k < 7; k++) put_sym(1'b0, 3'b000);
    chk("resync_data",      32'(o_data[0]), 0);
    chk("resync_valid",     32'(o_vld[0]),  1);
    chk("resync_frame_cnt", 32'(o_fcnt[0]), 1);
    idle(2);

    // Pre-Sof junk and gapped symbols
    clear();
    for (int i = 0; i < 3; i++) begin
      idle($urandom_range(0, 2));
      put_sym(1'b0, 3'($urandom_range(0, 7)));
    end
    send_frame(16'hA5C3, 1'b0, 50, 7);
    chk("gap_data",      32'(o_data[0]), 32'hA5C3);
    chk("gap_frame_cnt", 32'(o_fcnt[0]), 1);
    idle(2);

    // Reset mid-frame with a buffered word
    clear();
    rdy = 1'b0;
    send_frame(16'h1234, 1'b0, 0, 7);
    send_frame(16'hA5C3, 1'b0, 0, 5);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_valid",     32'(o_vld[0]),  0);
    chk("mid_rst_data",      32'(o_data[0]), 0);
    chk("mid_rst_frame_cnt", 32'(o_fcnt[0]), 0);
    check_all();
    idle(2);
    rst_n = 1'b1;
    rdy = 1'b1;
    send_frame(16'h0F0F, 1'b0, 0, 7);
    chk("post_rst_data",      32'(o_data[0]), 32'h0F0F);
    chk("post_rst_frame_cnt", 32'(o_fcnt[0]), 1);
    idle(2);

    // Random frames, truncations, errors, ready and clear activity
    clear();
    rand_rdy = 1'b1;
    clr_pct = 2;
    for (int i = 0; i < 80; i++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 6) : 7;
      send_frame(16'($urandom), ($urandom_range(0, 3) == 0), 40, n);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_rdy = 1'b0;
    clr_pct = 0;
    clr = 1'b0;
    rdy = 1'b1;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
